// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, requester ids and the command bundle for the
// memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int NREQ   = 3;
    localparam int ID_W   = 2;

    typedef logic [ID_W-1:0] req_id_t;

    localparam req_id_t REQ_FETCH = 2'd0;
    localparam req_id_t REQ_DATA  = 2'd1;
    localparam req_id_t REQ_LOAD  = 2'd2;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        req_id_t           id;
    } cmd_t;

    // Next requester id, wrapping modulo NREQ.
    function automatic req_id_t next_id(req_id_t id);
        return (int'(id) >= NREQ - 1) ? '0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake plus memory port bundle. master = requesters
// and memory, slave = the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        gnt;
    logic                   rvalid;
    req_id_t                rid;
    logic [DATA_W-1:0]      rdata;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_we;
    logic [DATA_W-1:0]      mem_rdata;

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rid, rdata, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rid, rdata, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational NREQ-way picker: first requester found searching
// from start upward (mod NREQ) gets the one-hot grant.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  req_id_t         start,
    output logic [NREQ-1:0] gnt,
    output req_id_t         id,
    output logic            any
);

    // Rotating search; the first hit blocks all later candidates.
    always_comb begin
        int unsigned idx;
        idx = 0;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(start) + k) % NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = req_id_t'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way memory port arbiter with capture/memory/response stages.
// Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    logic [NREQ-1:0] pick_gnt;
    req_id_t         pick_id;
    logic            pick_any;
    req_id_t         start;
    logic            xfer;
    cmd_t            sel;
    cmd_t            cmd;
    logic            cmd_valid;
    logic            rvalid_q;
    req_id_t         rid_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_t rr_ptr;

    // Winner's successor becomes highest priority next time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= next_id(pick_id);
        end
    end

    assign start = rr_ptr;
`else
    assign start = REQ_FETCH;
`endif

    arb_pick u_pick (
        .req   (bus.req),
        .start (start),
        .gnt   (pick_gnt),
        .id    (pick_id),
        .any   (pick_any)
    );

    // Reset wins over any request, so no grant is shown during it.
    assign bus.gnt = rst_n ? pick_gnt : '0;
    assign xfer    = rst_n & pick_any;

    // One-hot mux of the winner; idle ports never reach the command.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel.we    = bus.req_we[i];
                sel.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel.wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel.id    = req_id_t'(i);
            end
        end
    end

    // Capture stage: latch the transferred command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else if (xfer) begin
            cmd_valid <= 1'b1;
            cmd       <= sel;
        end else begin
            cmd_valid <= 1'b0;
            cmd.we    <= 1'b0;
        end
    end

    // Memory stage. The write is masked during reset so a command
    // caught by the reset edge never commits.
    assign bus.mem_addr  = cmd.addr;
    assign bus.mem_wdata = cmd.wdata;
    assign bus.mem_we    = rst_n & cmd_valid & cmd.we;

    // Response stage: register read data with its owner id.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= cmd_valid & ~cmd.we;
            rid_q    <= cmd.id;
            rdata_q  <= bus.mem_rdata;
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rid    = rid_q;
    assign bus.rdata  = rdata_q;

endmodule
